// File: rtl/cpu_debug_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_debug_ctrl
//   Debug controller sitting between a host command port and a CPU core.
//   It starts, pauses and single-steps the core, latches a halt and
//   streams the 32-entry register file out on a valid/ready channel.
//   It can also keep saturating execution statistics.
//
// Configuration:
//   DBG_STATS_EN  defined   -> five saturating CNT_W-bit statistics counters
//                 undefined -> no counter flops, cnt_* tied to 0, stats_clr unused
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_op      host command (00 RUN, 01 PAUSE, 10 STEP, 11 SCAN)
//   cmd_ready             command accepted when cmd_valid && cmd_ready
//   cpu_en                CPU core enable (registered)
//   cpu_halt .. cpu_branched  CPU status inputs
//   regfile_req_dbg       register index presented to the CPU debug port
//   regfile_data_dbg      combinational register data for regfile_req_dbg
//   scan_valid/idx/data   register-dump stream, scan_ready is its back-pressure
//   stats_clr             synchronous clear of all counters
//   cnt_*                 statistics counters
//   state_dbg             current FSM state
// -----------------------------------------------------------------------------
module cpu_debug_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    output logic             cpu_en,
    input  logic             cpu_halt,
    input  logic             cpu_valid_inst,
    input  logic             cpu_is_jump,
    input  logic             cpu_is_branch,
    input  logic             cpu_branched,
    output logic [4:0]       regfile_req_dbg,
    input  logic [31:0]      regfile_data_dbg,
    output logic             scan_valid,
    output logic [4:0]       scan_idx,
    output logic [31:0]      scan_data,
    input  logic             scan_ready,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] cnt_cycle,
    output logic [CNT_W-1:0] cnt_inst,
    output logic [CNT_W-1:0] cnt_jump,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_SCAN   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam logic [1:0] OP_RUN   = 2'b00;
    localparam logic [1:0] OP_PAUSE = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_SCAN  = 2'b11;

    state_t      state_r;
    state_t      next_state_s;
    logic        ret_halted_r;   // SCAN returns to HALTED rather than IDLE
    logic        cpu_en_r;
    logic        cmd_ready_r;
    logic        scan_valid_r;
    logic [4:0]  scan_idx_r;
    logic [31:0] scan_data_r;
    logic [4:0]  req_r;          // index of the word being fetched in SCAN
    logic        cmd_fire_s;
    logic        scan_done_s;

    assign cmd_fire_s  = cmd_valid && cmd_ready_r;
    assign scan_done_s = (state_r == ST_SCAN) && scan_valid_r && scan_ready &&
                         (scan_idx_r == 5'd31);

    // Next-state decode; halt has priority over any command in RUN and STEP.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_fire_s) begin
                    case (cmd_op)
                        OP_RUN:  next_state_s = ST_RUN;
                        OP_STEP: next_state_s = ST_STEP;
                        OP_SCAN: next_state_s = ST_SCAN;
                        default: next_state_s = ST_IDLE;
                    endcase
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cpu_halt) begin
                    next_state_s = ST_HALTED;
                end else if (cmd_fire_s && (cmd_op == OP_PAUSE)) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_STEP: begin
                if (cpu_halt) begin
                    next_state_s = ST_HALTED;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (scan_done_s) begin
                    next_state_s = ret_halted_r ? ST_HALTED : ST_IDLE;
                end else begin
                    next_state_s = ST_SCAN;
                end
            end
            ST_HALTED: begin
                if (cmd_fire_s && (cmd_op == OP_SCAN)) begin
                    next_state_s = ST_SCAN;
                end else begin
                    next_state_s = ST_HALTED;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register plus outputs decoded from the next state so they are flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ret_halted_r <= 1'b0;
            cpu_en_r     <= 1'b0;
            cmd_ready_r  <= 1'b1;
        end else begin
            state_r     <= next_state_s;
            cpu_en_r    <= (next_state_s == ST_RUN) || (next_state_s == ST_STEP);
            cmd_ready_r <= (next_state_s == ST_IDLE) || (next_state_s == ST_RUN) ||
                           (next_state_s == ST_HALTED);
            if ((next_state_s == ST_SCAN) && (state_r != ST_SCAN)) begin
                ret_halted_r <= (state_r == ST_HALTED);
            end else begin
                ret_halted_r <= ret_halted_r;
            end
        end
    end

    // Register-dump stream: fetch a word while idle, hold it until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_valid_r <= 1'b0;
            scan_idx_r   <= 5'd0;
            scan_data_r  <= 32'd0;
            req_r        <= 5'd0;
        end else if (state_r == ST_SCAN) begin
            if (!scan_valid_r) begin
                scan_valid_r <= 1'b1;
                scan_idx_r   <= req_r;
                scan_data_r  <= regfile_data_dbg;
            end else if (scan_ready) begin
                scan_valid_r <= 1'b0;
                req_r        <= (scan_idx_r == 5'd31) ? 5'd0 : (scan_idx_r + 5'd1);
            end else begin
                scan_valid_r <= scan_valid_r;
            end
        end else begin
            scan_valid_r <= 1'b0;
            req_r        <= 5'd0;
        end
    end

    assign cmd_ready       = cmd_ready_r;
    assign cpu_en          = cpu_en_r;
    assign regfile_req_dbg = req_r;
    assign scan_valid      = scan_valid_r;
    assign scan_idx        = scan_idx_r;
    assign scan_data       = scan_data_r;
    assign state_dbg       = state_r;

`ifdef DBG_STATS_EN
    logic [CNT_W-1:0] cnt_cycle_r;
    logic [CNT_W-1:0] cnt_inst_r;
    logic [CNT_W-1:0] cnt_jump_r;
    logic [CNT_W-1:0] cnt_branch_r;
    logic [CNT_W-1:0] cnt_taken_r;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic inc);
        if (inc && (v != {CNT_W{1'b1}})) begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    // Statistics counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            cnt_cycle_r  <= {CNT_W{1'b0}};
            cnt_inst_r   <= {CNT_W{1'b0}};
            cnt_jump_r   <= {CNT_W{1'b0}};
            cnt_branch_r <= {CNT_W{1'b0}};
            cnt_taken_r  <= {CNT_W{1'b0}};
        end else begin
            cnt_cycle_r  <= sat_inc(cnt_cycle_r,  cpu_en_r);
            cnt_inst_r   <= sat_inc(cnt_inst_r,   cpu_en_r && cpu_valid_inst);
            cnt_jump_r   <= sat_inc(cnt_jump_r,   cpu_en_r && cpu_is_jump);
            cnt_branch_r <= sat_inc(cnt_branch_r, cpu_en_r && cpu_is_branch);
            cnt_taken_r  <= sat_inc(cnt_taken_r,  cpu_en_r && cpu_branched);
        end
    end

    assign cnt_cycle  = cnt_cycle_r;
    assign cnt_inst   = cnt_inst_r;
    assign cnt_jump   = cnt_jump_r;
    assign cnt_branch = cnt_branch_r;
    assign cnt_taken  = cnt_taken_r;
`else
    // Status inputs only feed the counters, so they are sunk here.
    logic unused_stats_s;
    assign unused_stats_s = ^{stats_clr, cpu_valid_inst, cpu_is_jump,
                              cpu_is_branch, cpu_branched};

    assign cnt_cycle  = {CNT_W{1'b0}};
    assign cnt_inst   = {CNT_W{1'b0}};
    assign cnt_jump   = {CNT_W{1'b0}};
    assign cnt_branch = {CNT_W{1'b0}};
    assign cnt_taken  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Scoreboard bench for cpu_debug_ctrl: stimulus queues expected values,
// a negedge monitor pops and compares them.
module tb_cpu_debug_ctrl;

    localparam logic [1:0] OP_RUN   = 2'b00;
    localparam logic [1:0] OP_PAUSE = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_SCAN  = 2'b11;

    localparam int S_STATE = 0, S_EN = 1, S_RDY = 2, S_SV = 3, S_REQ = 4;
    localparam int S_CCYC = 5, S_CINST = 6, S_CJMP = 7, S_CBR = 8, S_CTK = 9;
    localparam int S_SIDX = 10, S_SDATA = 11, S_C8CYC = 12, S_BEATS = 13, S_QLEFT = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, cmd_valid, cpu_halt, cpu_valid_inst, cpu_is_jump;
    logic        cpu_is_branch, cpu_branched, scan_ready, stats_clr;
    logic [1:0]  cmd_op;

    logic        cmd_ready, cpu_en, scan_valid;
    logic [4:0]  regfile_req_dbg, scan_idx;
    logic [31:0] regfile_data_dbg, scan_data;
    logic [31:0] cnt_cycle, cnt_inst, cnt_jump, cnt_branch, cnt_taken;
    logic [2:0]  state_dbg;

    logic        cmd_ready8, cpu_en8, scan_valid8;
    logic [4:0]  req8, scan_idx8;
    logic [31:0] data8, scan_data8;
    logic [7:0]  c8_cycle, c8_inst, c8_jump, c8_branch, c8_taken;
    logic [2:0]  state8;

    // Register file model: r[i] = 0x100 + i
    assign regfile_data_dbg = 32'h100 + {27'd0, regfile_req_dbg};
    assign data8            = 32'h100 + {27'd0, req8};

    cpu_debug_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .cpu_en(cpu_en), .cpu_halt(cpu_halt),
        .cpu_valid_inst(cpu_valid_inst), .cpu_is_jump(cpu_is_jump),
        .cpu_is_branch(cpu_is_branch), .cpu_branched(cpu_branched),
        .regfile_req_dbg(regfile_req_dbg), .regfile_data_dbg(regfile_data_dbg),
        .scan_valid(scan_valid), .scan_idx(scan_idx), .scan_data(scan_data),
        .scan_ready(scan_ready), .stats_clr(stats_clr),
        .cnt_cycle(cnt_cycle), .cnt_inst(cnt_inst), .cnt_jump(cnt_jump),
        .cnt_branch(cnt_branch), .cnt_taken(cnt_taken), .state_dbg(state_dbg)
    );

    cpu_debug_ctrl #(.CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready8), .cpu_en(cpu_en8), .cpu_halt(cpu_halt),
        .cpu_valid_inst(cpu_valid_inst), .cpu_is_jump(cpu_is_jump),
        .cpu_is_branch(cpu_is_branch), .cpu_branched(cpu_branched),
        .regfile_req_dbg(req8), .regfile_data_dbg(data8),
        .scan_valid(scan_valid8), .scan_idx(scan_idx8), .scan_data(scan_data8),
        .scan_ready(scan_ready), .stats_clr(stats_clr),
        .cnt_cycle(c8_cycle), .cnt_inst(c8_inst), .cnt_jump(c8_jump),
        .cnt_branch(c8_branch), .cnt_taken(c8_taken), .state_dbg(state8)
    );

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t        chk_q[$];
    logic [36:0] stream_q[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    int          beats = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Counter expectations collapse to 0 when statistics are compiled out.
    function automatic logic [31:0] cx(input logic [31:0] v);
`ifdef DBG_STATS_EN
        return v;
`else
        return (v == 32'hFFFF_FFFF) ? 32'd0 : 32'd0;
`endif
    endfunction

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            S_STATE: return {29'd0, state_dbg};
            S_EN:    return {31'd0, cpu_en};
            S_RDY:   return {31'd0, cmd_ready};
            S_SV:    return {31'd0, scan_valid};
            S_REQ:   return {27'd0, regfile_req_dbg};
            S_CCYC:  return cnt_cycle;
            S_CINST: return cnt_inst;
            S_CJMP:  return cnt_jump;
            S_CBR:   return cnt_branch;
            S_CTK:   return cnt_taken;
            S_SIDX:  return {27'd0, scan_idx};
            S_SDATA: return scan_data;
            S_C8CYC: return {24'd0, c8_cycle};
            S_BEATS: return beats;
            S_QLEFT: return 32'(stream_q.size());
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            S_STATE: return "state_dbg";
            S_EN:    return "cpu_en";
            S_RDY:   return "cmd_ready";
            S_SV:    return "scan_valid";
            S_REQ:   return "regfile_req_dbg";
            S_CCYC:  return "cnt_cycle";
            S_CINST: return "cnt_inst";
            S_CJMP:  return "cnt_jump";
            S_CBR:   return "cnt_branch";
            S_CTK:   return "cnt_taken";
            S_SIDX:  return "scan_idx";
            S_SDATA: return "scan_data";
            S_C8CYC: return "cnt_cycle_w8";
            S_BEATS: return "scan_beats";
            S_QLEFT: return "beats_left";
            default: return "unknown";
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input int sel, input logic [31:0] exp);
        chk_t c;
        c.due = cyc;
        c.sel = sel;
        c.exp = exp;
        chk_q.push_back(c);
    endtask

    task automatic send(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic push_beats();
        for (int i = 0; i < 32; i++) begin
            stream_q.push_back({i[4:0], 32'h100 + i});
        end
        beats = 0;
    endtask

    // Drive scan_ready until the FSM leaves SCAN, then check where it landed.
    task automatic run_scan(input bit toggle, input logic [2:0] ret_state);
        bit done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            scan_ready = toggle ? k[0] : 1'b1;
            expect_v(S_EN, 32'd0);
            tick();
            if (state_dbg != 3'd3) done = 1'b1;
        end
        scan_ready = 1'b0;
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL scan_timeout: still in SCAN after 300 cycles, required exit");
        end
        expect_v(S_STATE, {29'd0, ret_state});
        expect_v(S_SV, 32'd0);
        expect_v(S_REQ, 32'd0);
        expect_v(S_BEATS, 32'd32);
    endtask

    // Monitor: drains due checks, scores stream beats, checks hold under stall.
    initial begin
        chk_t        c;
        logic [31:0] act;
        logic [36:0] e;
        logic        p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b0;
        logic [4:0]  p_idx = 5'd0;
        logic [31:0] p_data = 32'd0;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0 && chk_q[0].due <= cyc) begin
                c   = chk_q.pop_front();
                act = probe(c.sel);
                n_vec++;
                if (act !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h",
                             sel_name(c.sel), cyc, act, c.exp);
                end
            end
            if (rst_n && scan_valid && scan_ready) begin
                beats++;
                n_vec++;
                if (stream_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scan_extra_beat: got idx %0d data 0x%0h, expected no beat",
                             scan_idx, scan_data);
                end else begin
                    e = stream_q.pop_front();
                    if ({scan_idx, scan_data} !== e) begin
                        n_fail++;
                        $display("FAIL scan_beat: got idx %0d data 0x%0h, expected idx %0d data 0x%0h",
                                 scan_idx, scan_data, e[36:32], e[31:0]);
                    end
                end
            end
            if (rst_n && p_rst && p_valid && !p_ready) begin
                n_vec++;
                if ({scan_valid, scan_idx, scan_data} !== {1'b1, p_idx, p_data}) begin
                    n_fail++;
                    $display("FAIL scan_hold: got v%0b idx %0d data 0x%0h, expected v1 idx %0d data 0x%0h",
                             scan_valid, scan_idx, scan_data, p_idx, p_data);
                end
            end
            p_valid = scan_valid;
            p_ready = scan_ready;
            p_rst   = rst_n;
            p_idx   = scan_idx;
            p_data  = scan_data;
        end
    end

    // Stimulus
    initial begin
        bit found;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_RUN; cpu_halt = 1'b0;
        cpu_valid_inst = 1'b0; cpu_is_jump = 1'b0; cpu_is_branch = 1'b0;
        cpu_branched = 1'b0; scan_ready = 1'b0; stats_clr = 1'b0;
        tick();
        tick();
        // Reset state
        expect_v(S_STATE, 32'd0); expect_v(S_EN, 32'd0); expect_v(S_RDY, 32'd1);
        expect_v(S_SV, 32'd0); expect_v(S_REQ, 32'd0); expect_v(S_SIDX, 32'd0);
        expect_v(S_SDATA, 32'd0); expect_v(S_CCYC, cx(32'd0)); expect_v(S_CINST, cx(32'd0));
        rst_n = 1'b1;
        tick();

        // Single step: one enabled cycle, then IDLE
        cpu_valid_inst = 1'b1;
        send(OP_STEP);
        expect_v(S_STATE, 32'd2); expect_v(S_EN, 32'd1); expect_v(S_RDY, 32'd0);
        tick();
        cpu_valid_inst = 1'b0;
        expect_v(S_STATE, 32'd0); expect_v(S_EN, 32'd0); expect_v(S_RDY, 32'd1);
        expect_v(S_CCYC, cx(32'd1)); expect_v(S_CINST, cx(32'd1));

        // PAUSE in IDLE has no effect; then clear statistics
        send(OP_PAUSE);
        expect_v(S_STATE, 32'd0);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        expect_v(S_CCYC, cx(32'd0)); expect_v(S_CINST, cx(32'd0));

        // RUN for 10 cycles, STEP ignored mid-run, PAUSE on the 10th
        send(OP_RUN);
        expect_v(S_STATE, 32'd1); expect_v(S_EN, 32'd1);
        for (int i = 0; i < 10; i++) begin
            cpu_valid_inst = 1'b1;
            cpu_is_branch  = (i % 3 == 0);
            cpu_branched   = (i % 3 == 0) && (i < 9);
            cpu_is_jump    = (i == 4);
            cmd_valid      = (i == 5) || (i == 9);
            cmd_op         = (i == 9) ? OP_PAUSE : OP_STEP;
            tick();
            if (i == 5) begin
                expect_v(S_STATE, 32'd1); expect_v(S_EN, 32'd1);
            end
        end
        cmd_valid = 1'b0; cpu_valid_inst = 1'b0; cpu_is_branch = 1'b0;
        cpu_branched = 1'b0; cpu_is_jump = 1'b0;
        expect_v(S_STATE, 32'd0); expect_v(S_EN, 32'd0);
        expect_v(S_CCYC, cx(32'd10)); expect_v(S_CINST, cx(32'd10));
        expect_v(S_CJMP, cx(32'd1)); expect_v(S_CBR, cx(32'd4)); expect_v(S_CTK, cx(32'd3));
        tick();
        expect_v(S_CCYC, cx(32'd10));

        // SCAN from IDLE with scan_ready toggling
        send(OP_SCAN);
        expect_v(S_STATE, 32'd3); expect_v(S_EN, 32'd0); expect_v(S_RDY, 32'd0);
        expect_v(S_SV, 32'd0);
        push_beats();
        run_scan(1'b1, 3'd0);
        tick();

        // Halt beats PAUSE in the same RUN cycle; HALTED ignores RUN/STEP/PAUSE
        send(OP_RUN);
        expect_v(S_STATE, 32'd1);
        cpu_halt = 1'b1;
        send(OP_PAUSE);
        cpu_halt = 1'b0;
        expect_v(S_STATE, 32'd4); expect_v(S_EN, 32'd0); expect_v(S_RDY, 32'd1);
        send(OP_RUN);
        expect_v(S_STATE, 32'd4); expect_v(S_EN, 32'd0);
        send(OP_STEP);
        expect_v(S_STATE, 32'd4); expect_v(S_EN, 32'd0);
        send(OP_PAUSE);
        expect_v(S_STATE, 32'd4);

        // SCAN from HALTED returns to HALTED
        send(OP_SCAN);
        expect_v(S_STATE, 32'd3);
        push_beats();
        run_scan(1'b0, 3'd4);
        tick();

        // Reset mid-SCAN at idx 5
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send(OP_RUN);
        tick();
        tick();
        send(OP_PAUSE);
        expect_v(S_CCYC, cx(32'd3));
        send(OP_SCAN);
        push_beats();
        scan_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            tick();
            if (scan_valid && scan_idx == 5'd5) found = 1'b1;
        end
        if (!found) begin
            n_vec++;
            n_fail++;
            $display("FAIL scan_idx5_timeout: idx 5 never presented, required within 60 cycles");
        end
        scan_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        expect_v(S_STATE, 32'd0); expect_v(S_SV, 32'd0); expect_v(S_EN, 32'd0);
        expect_v(S_REQ, 32'd0); expect_v(S_SIDX, 32'd0); expect_v(S_CCYC, cx(32'd0));
        expect_v(S_QLEFT, 32'd27);
        rst_n = 1'b1;
        tick();
        stream_q.delete();
        scan_ready = 1'b1;
        repeat (5) tick();
        scan_ready = 1'b0;
        expect_v(S_STATE, 32'd0); expect_v(S_SV, 32'd0);

        // Saturation with CNT_W = 8, then clear while running
        send(OP_RUN);
        repeat (300) tick();
        expect_v(S_C8CYC, cx(32'd255)); expect_v(S_CCYC, cx(32'd300));
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        expect_v(S_C8CYC, cx(32'd0)); expect_v(S_CCYC, cx(32'd0));
        tick();
        expect_v(S_C8CYC, cx(32'd1)); expect_v(S_CCYC, cx(32'd1));
        send(OP_PAUSE);
        expect_v(S_STATE, 32'd0); expect_v(S_EN, 32'd0);
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
